// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Purpose : Shared definitions for the execute stage. These are the alu_op code
//           constants, the ALU_OP_W width constant, the mul/div FSM state enum,
//           and helpers that classify M-extension operations.
// Ports   : none (package)
// Config  : the M-extension codes are only executed when EXE_STAGE_MULDIV_EN
//           is defined. Without it they decode as undefined operations.
// -----------------------------------------------------------------------------
package exe_pkg;

   localparam int ALU_OP_W = 5;

   localparam logic [ALU_OP_W-1:0] OP_ADD    = 5'h00;
   localparam logic [ALU_OP_W-1:0] OP_SUB    = 5'h01;
   localparam logic [ALU_OP_W-1:0] OP_AND    = 5'h02;
   localparam logic [ALU_OP_W-1:0] OP_OR     = 5'h03;
   localparam logic [ALU_OP_W-1:0] OP_XOR    = 5'h04;
   localparam logic [ALU_OP_W-1:0] OP_SLL    = 5'h05;
   localparam logic [ALU_OP_W-1:0] OP_SRL    = 5'h06;
   localparam logic [ALU_OP_W-1:0] OP_SRA    = 5'h07;
   localparam logic [ALU_OP_W-1:0] OP_SLT    = 5'h08;
   localparam logic [ALU_OP_W-1:0] OP_SLTU   = 5'h09;
   localparam logic [ALU_OP_W-1:0] OP_COPY1  = 5'h0A;
   localparam logic [ALU_OP_W-1:0] OP_MUL    = 5'h10;
   localparam logic [ALU_OP_W-1:0] OP_MULH   = 5'h11;
   localparam logic [ALU_OP_W-1:0] OP_MULHSU = 5'h12;
   localparam logic [ALU_OP_W-1:0] OP_MULHU  = 5'h13;
   localparam logic [ALU_OP_W-1:0] OP_DIV    = 5'h14;
   localparam logic [ALU_OP_W-1:0] OP_DIVU   = 5'h15;
   localparam logic [ALU_OP_W-1:0] OP_REM    = 5'h16;
   localparam logic [ALU_OP_W-1:0] OP_REMU   = 5'h17;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   endfunction

   function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/exe_muldiv_unit.sv
// -----------------------------------------------------------------------------
// exe_muldiv_unit
// Purpose : Multi-cycle multiply/divide engine for the execute stage.
//           - Multiply: the product is formed when the op starts. It is then
//             held for MUL_LAT cycles in MD_MUL.
//           - Divide: XLEN restoring iterations run on the operand magnitudes,
//             one per cycle. Signs are applied on the last iteration.
//           - Divide by zero and signed overflow skip straight to MD_DONE.
// Ports   : clk, rst_n (async, active low)
//           i_start      valid M op held by the pipeline register
//           i_flush      abort and return to idle
//           i_ms_allowin downstream accepts; leaves MD_DONE
//           i_alu_op, i_op1, i_op2  latched operation and operands
//           o_busy (state != idle), o_done (result ready), o_result
// Config  : only instantiated when EXE_STAGE_MULDIV_EN is defined.
// -----------------------------------------------------------------------------
module exe_muldiv_unit
   import exe_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic                i_flush,
   input  logic                i_ms_allowin,
   input  logic [ALU_OP_W-1:0] i_alu_op,
   input  logic [XLEN-1:0]     i_op1,
   input  logic [XLEN-1:0]     i_op2,
   output logic                o_busy,
   output logic                o_done,
   output logic [XLEN-1:0]     o_result
);

   localparam int CNT_W = $clog2(XLEN);

   md_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_quo, r_rem, r_div, r_result;
   logic             r_neg_q, r_neg_r, r_is_rem;

   logic              w_sign_div, w_is_rem, w_op1_neg, w_op2_neg, w_ovf;
   logic [XLEN-1:0]   w_abs1, w_abs2;
   logic              w_sa, w_sb;
   logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
   logic [XLEN-1:0]   w_mul_res;
   logic [XLEN:0]     w_rem_sh, w_diff;
   logic [XLEN-1:0]   w_quo_nx, w_rem_nx, w_q_fin, w_r_fin;

   // Decode the signs and magnitudes of the operands for division.
   assign w_sign_div = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
   assign w_is_rem   = (i_alu_op == OP_REM) || (i_alu_op == OP_REMU);
   assign w_op1_neg  = w_sign_div & i_op1[XLEN-1];
   assign w_op2_neg  = w_sign_div & i_op2[XLEN-1];
   assign w_abs1     = w_op1_neg ? (~i_op1 + 1'b1) : i_op1;
   assign w_abs2     = w_op2_neg ? (~i_op2 + 1'b1) : i_op2;
   assign w_ovf      = w_sign_div && (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op2 == '1);

   // Sign-extend (or zero-extend) each operand to 2*XLEN bits. The low 2*XLEN
   // bits of the product are then correct for every signedness mix.
   assign w_sa      = (i_alu_op == OP_MULH) || (i_alu_op == OP_MULHSU);
   assign w_sb      = (i_alu_op == OP_MULH);
   assign w_mul_a   = {{XLEN{w_sa & i_op1[XLEN-1]}}, i_op1};
   assign w_mul_b   = {{XLEN{w_sb & i_op2[XLEN-1]}}, i_op2};
   assign w_prod    = w_mul_a * w_mul_b;
   assign w_mul_res = (i_alu_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   // One restoring step. The dividend shifts out of r_quo MSB-first, and
   // quotient bits shift in at the LSB.
   assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_div};
   assign w_quo_nx = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
   assign w_rem_nx = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
   assign w_q_fin  = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
   assign w_r_fin  = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= MD_IDLE;
         r_cnt    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_rem <= 1'b0;
         r_result <= '0;
      end else if (i_flush) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (i_start) begin
                  if (is_mul_op(i_alu_op)) begin
                     r_result <= w_mul_res;
                     r_cnt    <= CNT_W'(MUL_LAT - 1);
                     r_state  <= MD_MUL;
                  end else if (i_op2 == '0) begin
                     r_result <= w_is_rem ? i_op1 : '1;
                     r_state  <= MD_DONE;
                  end else if (w_ovf) begin
                     r_result <= w_is_rem ? '0 : i_op1;
                     r_state  <= MD_DONE;
                  end else begin
                     r_quo    <= w_abs1;
                     r_rem    <= '0;
                     r_div    <= w_abs2;
                     r_neg_q  <= w_op1_neg ^ w_op2_neg;
                     r_neg_r  <= w_op1_neg;
                     r_is_rem <= w_is_rem;
                     r_cnt    <= CNT_W'(XLEN - 1);
                     r_state  <= MD_DIV;
                  end
               end
            end
            MD_MUL: begin
               if (r_cnt == '0) r_state <= MD_DONE;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            MD_DIV: begin
               r_quo <= w_quo_nx;
               r_rem <= w_rem_nx;
               if (r_cnt == '0) begin
                  r_result <= r_is_rem ? w_r_fin : w_q_fin;
                  r_state  <= MD_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            MD_DONE: begin
               if (i_ms_allowin) r_state <= MD_IDLE;
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   assign o_busy   = (r_state != MD_IDLE);
   assign o_done   = (r_state == MD_DONE);
   assign o_result = r_result;

endmodule

// File: rtl/exe_stage_md.sv
// -----------------------------------------------------------------------------
// exe_stage_md
// Purpose : Execute pipeline stage. It contains the valid/allowin handshake,
//           the pipeline register, a single-cycle ALU and an optional
//           multi-cycle mul/div unit.
// Ports   : clk, rst_n (async, active low)
//           ds_to_es_valid / es_allowin    handshake with decode
//           es_to_ms_valid / ms_allowin    handshake with memory stage
//           flush                          kill the held instruction
//           op1, op2, alu_op, rd_in, rd_wen_in, pc_in   instruction fields
//           res_out, rd_out, rd_wen_out, pc_out         latched results
//           busy       mul/div FSM not idle
//           fwd_valid  result usable for the decode bypass
// Config  : define EXE_STAGE_MULDIV_EN to enable the M-extension ops. When it
//           is undefined, they behave as undefined ops: the result is 0 and
//           they complete in one cycle.
// -----------------------------------------------------------------------------
module exe_stage_md
   import exe_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ds_to_es_valid,
   output logic                es_allowin,
   input  logic                ms_allowin,
   output logic                es_to_ms_valid,
   input  logic                flush,
   input  logic [XLEN-1:0]     op1,
   input  logic [XLEN-1:0]     op2,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [4:0]          rd_in,
   input  logic                rd_wen_in,
   input  logic [XLEN-1:0]     pc_in,
   output logic [XLEN-1:0]     res_out,
   output logic [4:0]          rd_out,
   output logic                rd_wen_out,
   output logic [XLEN-1:0]     pc_out,
   output logic                busy,
   output logic                fwd_valid
);

   localparam int SHW = $clog2(XLEN);

   logic                r_es_valid;
   logic [XLEN-1:0]     r_op1, r_op2, r_pc;
   logic [ALU_OP_W-1:0] r_alu_op;
   logic [4:0]          r_rd;
   logic                r_rd_wen;

   logic                w_ready_go, w_capture, w_is_m;
   logic [SHW-1:0]      w_shamt;
   logic [XLEN-1:0]     w_alu_res;

   assign es_allowin = !r_es_valid || (w_ready_go && ms_allowin);
   assign w_capture  = ds_to_es_valid && es_allowin && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_es_valid <= 1'b0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_pc       <= '0;
         r_alu_op   <= '0;
         r_rd       <= '0;
         r_rd_wen   <= 1'b0;
      end else begin
         if (flush)           r_es_valid <= 1'b0;
         else if (es_allowin) r_es_valid <= ds_to_es_valid;
         if (w_capture) begin
            r_op1    <= op1;
            r_op2    <= op2;
            r_pc     <= pc_in;
            r_alu_op <= alu_op;
            r_rd     <= rd_in;
            r_rd_wen <= rd_wen_in;
         end
      end
   end

   assign w_shamt = r_op2[SHW-1:0];

   // Codes outside the list, including the M ops, produce 0.
   always_comb begin
      w_alu_res = '0;
      case (r_alu_op)
         OP_ADD:   w_alu_res = r_op1 + r_op2;
         OP_SUB:   w_alu_res = r_op1 - r_op2;
         OP_AND:   w_alu_res = r_op1 & r_op2;
         OP_OR:    w_alu_res = r_op1 | r_op2;
         OP_XOR:   w_alu_res = r_op1 ^ r_op2;
         OP_SLL:   w_alu_res = r_op1 << w_shamt;
         OP_SRL:   w_alu_res = r_op1 >> w_shamt;
         OP_SRA:   w_alu_res = $unsigned($signed(r_op1) >>> w_shamt);
         OP_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_op1) < $signed(r_op2))};
         OP_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, (r_op1 < r_op2)};
         OP_COPY1: w_alu_res = r_op1;
         default:  w_alu_res = '0;
      endcase
   end

`ifdef EXE_STAGE_MULDIV_EN
   logic            w_md_busy, w_md_done;
   logic [XLEN-1:0] w_md_res;

   assign w_is_m = is_mul_op(r_alu_op) || is_div_op(r_alu_op);

   exe_muldiv_unit #(
      .XLEN    (XLEN),
      .MUL_LAT (MUL_LAT)
   ) u_muldiv (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (r_es_valid && w_is_m),
      .i_flush      (flush),
      .i_ms_allowin (ms_allowin),
      .i_alu_op     (r_alu_op),
      .i_op1        (r_op1),
      .i_op2        (r_op2),
      .o_busy       (w_md_busy),
      .o_done       (w_md_done),
      .o_result     (w_md_res)
   );

   assign w_ready_go = w_is_m ? w_md_done : 1'b1;
   assign res_out    = w_is_m ? w_md_res : w_alu_res;
   assign busy       = w_md_busy;
`else
   assign w_is_m     = 1'b0;
   assign w_ready_go = 1'b1;
   assign res_out    = w_alu_res;
   assign busy       = 1'b0;
`endif

   // A flushed instruction must never reach the memory stage.
   assign es_to_ms_valid = r_es_valid && w_ready_go && !flush;
   assign rd_out         = r_rd;
   assign rd_wen_out     = r_rd_wen && r_es_valid;
   assign pc_out         = r_pc;
   assign fwd_valid      = r_es_valid && w_ready_go && r_rd_wen && (r_rd != 5'd0);

endmodule

// File: tb/tb_exe_stage_md.sv
// -----------------------------------------------------------------------------
// tb_exe_stage_md
// Purpose : Directed self-checking bench for exe_stage_md (XLEN=32, MUL_LAT=3).
//           With EXE_STAGE_MULDIV_EN defined, the M ops are checked for
//           latency and results. Without it, they are checked as undefined
//           ops.
// -----------------------------------------------------------------------------
module tb_exe_stage_md;
   import exe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ds_to_es_valid = 1'b0;
   logic        es_allowin;
   logic        ms_allowin = 1'b1;
   logic        es_to_ms_valid;
   logic        flush = 1'b0;
   logic [31:0] op1 = '0, op2 = '0, pc_in = '0;
   logic [4:0]  alu_op = '0;
   logic [4:0]  rd_in = '0;
   logic        rd_wen_in = 1'b0;
   logic [31:0] res_out, pc_out;
   logic [4:0]  rd_out;
   logic        rd_wen_out, busy, fwd_valid;

   int checks = 0;
   int errors = 0;

   exe_stage_md #(.XLEN(32), .MUL_LAT(3)) dut (
      .clk(clk), .rst_n(rst_n), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
      .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid), .flush(flush),
      .op1(op1), .op2(op2), .alu_op(alu_op), .rd_in(rd_in), .rd_wen_in(rd_wen_in),
      .pc_in(pc_in), .res_out(res_out), .rd_out(rd_out), .rd_wen_out(rd_wen_out),
      .pc_out(pc_out), .busy(busy), .fwd_valid(fwd_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for one edge.
   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wen, input logic [31:0] pc);
      ds_to_es_valid = 1'b1;
      alu_op = op; op1 = a; op2 = b; rd_in = rd; rd_wen_in = wen; pc_in = pc;
      tick();
      ds_to_es_valid = 1'b0;
   endtask

   task automatic alu_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      send(op, a, b, 5'd1, 1'b1, 32'h200);
      check({tag, "_valid"}, es_to_ms_valid, 1);
      check({tag, "_res"}, res_out, exp);
   endtask

   // Run an M op with ms_allowin high. Count the cycles until es_to_ms_valid
   // rises, check the result, then let it leave.
   task automatic m_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cnt, input logic [31:0] exp);
      int cnt;
      send(op, a, b, 5'd2, 1'b1, 32'h300);
      cnt = 0;
      while (!es_to_ms_valid && cnt < 100) begin
         cnt++;
         tick();
      end
      check({tag, "_lat"}, cnt, exp_cnt);
      check({tag, "_res"}, res_out, exp);
      check({tag, "_busy_done"}, busy, 1);
      tick();
      check({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick(); tick();
      check("rst_to_ms", es_to_ms_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_fwd", fwd_valid, 0);
      check("rst_res", res_out, 0);
      check("rst_allowin", es_allowin, 1);
      check("rst_pc", pc_out, 0);
      rst_n = 1'b1;
      tick();

      // ADD 5+7 is visible in the cycle after capture.
      send(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 32'h100);
      check("add_valid", es_to_ms_valid, 1);
      check("add_res", res_out, 32'd12);
      check("add_rd", rd_out, 5'd3);
      check("add_wen", rd_wen_out, 1);
      check("add_pc", pc_out, 32'h100);
      check("add_fwd", fwd_valid, 1);
      tick();
      check("idle_valid", es_to_ms_valid, 0);
      check("idle_wen", rd_wen_out, 0);

      // ALU vectors, back-to-back
      alu_vec("sub",   OP_SUB,   32'd5, 32'd7, 32'hFFFF_FFFE);
      alu_vec("and",   OP_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
      alu_vec("or",    OP_OR,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
      alu_vec("xor",   OP_XOR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
      alu_vec("sll",   OP_SLL,   32'd1, 32'd33, 32'd2);
      alu_vec("srl",   OP_SRL,   32'h8000_0000, 32'd4, 32'h0800_0000);
      alu_vec("sra",   OP_SRA,   32'h8000_0000, 32'd4, 32'hF800_0000);
      alu_vec("slt",   OP_SLT,   32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_vec("sltu",  OP_SLTU,  32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_vec("copy1", OP_COPY1, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
      alu_vec("undef", 5'h1F,    32'd9, 32'd9, 32'd0);

      // rd = 0 never forwards.
      send(OP_ADD, 32'd1, 32'd1, 5'd0, 1'b1, 32'h204);
      check("rd0_fwd", fwd_valid, 0);
      check("rd0_wen", rd_wen_out, 1);
      tick();

      // Backpressure: a held instruction blocks capture.
      ms_allowin = 1'b0;
      send(OP_ADD, 32'd1, 32'd2, 5'd4, 1'b1, 32'h400);
      check("bp_allowin", es_allowin, 0);
      ds_to_es_valid = 1'b1; alu_op = OP_ADD; op1 = 32'd10; op2 = 32'd10; pc_in = 32'h404;
      tick();
      check("bp_hold_res", res_out, 32'd3);
      check("bp_hold_pc", pc_out, 32'h400);
      ms_allowin = 1'b1;
      tick();
      ds_to_es_valid = 1'b0;
      check("bp_next_res", res_out, 32'd20);

      // Flush a held ALU instruction while stalled.
      ms_allowin = 1'b0;
      tick();
      send(OP_ADD, 32'd3, 32'd3, 5'd5, 1'b1, 32'h500);
      flush = 1'b1;
      #1;
      check("flush_no_out", es_to_ms_valid, 0);
      tick();
      flush = 1'b0;
      ms_allowin = 1'b1;
      check("flush_cleared", es_to_ms_valid, 0);

      // Flush overrides a simultaneous capture.
      flush = 1'b1;
      send(OP_ADD, 32'd4, 32'd4, 5'd6, 1'b1, 32'h600);
      flush = 1'b0;
      check("flush_cap", es_to_ms_valid, 0);
      tick();

`ifdef EXE_STAGE_MULDIV_EN
      m_vec("div",     OP_DIV,    32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA);
      m_vec("rem",     OP_REM,    32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFE);
      m_vec("divu0",   OP_DIVU,   32'd9, 32'd0, 1, 32'hFFFF_FFFF);
      m_vec("remu0",   OP_REMU,   32'd9, 32'd0, 1, 32'd9);
      m_vec("divovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
      m_vec("removf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
      m_vec("mulhu",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFE);
      m_vec("mul",     OP_MUL,    32'd7, 32'hFFFF_FFFD, 4, 32'hFFFF_FFEB);
      m_vec("mulh",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'd0);
      m_vec("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF);
      m_vec("divu",    OP_DIVU,   32'd100, 32'd7, 33, 32'd14);

      // Flush on the 10th DIV cycle
      send(OP_DIV, 32'd100, 32'd7, 5'd7, 1'b1, 32'h700);
      for (int i = 0; i < 10; i++) tick();
      check("fl_busy_before", busy, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_busy", busy, 0);
      check("fl_allowin", es_allowin, 1);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (es_to_ms_valid) seen++;
            tick();
         end
         check("fl_no_result", seen, 0);
      end

      // DONE holds its result while ms_allowin is low.
      ms_allowin = 1'b0;
      send(OP_DIVU, 32'd100, 32'd7, 5'd8, 1'b1, 32'h800);
      begin
         int cnt;
         cnt = 0;
         while (!es_to_ms_valid && cnt < 100) begin
            cnt++;
            tick();
         end
         check("hold_lat", cnt, 33);
      end
      for (int i = 0; i < 5; i++) tick();
      check("hold_res", res_out, 32'd14);
      check("hold_valid", es_to_ms_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_allowin", es_allowin, 0);
      ms_allowin = 1'b1;
      tick();
      check("hold_release", busy, 0);

      // Reset mid-division aborts it.
      send(OP_DIV, 32'd50, 32'd3, 5'd9, 1'b1, 32'h900);
      for (int i = 0; i < 5; i++) tick();
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_valid", es_to_ms_valid, 0);
      check("arst_res", res_out, 0);
      tick();
      rst_n = 1'b1;
      tick();
`else
      // Without the mul/div unit, M ops are undefined: 0, single cycle.
      send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'h300);
      check("nomd_mul_valid", es_to_ms_valid, 1);
      check("nomd_mul_res", res_out, 32'd0);
      check("nomd_mul_busy", busy, 0);
      send(OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd2, 1'b1, 32'h304);
      check("nomd_div_valid", es_to_ms_valid, 1);
      check("nomd_div_res", res_out, 32'd0);
      check("nomd_div_busy", busy, 0);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_stage_md.md
EXE_STAGE_MD -- requirements
Module: exe_stage_md

Interface
REQ-001 Param XLEN, default 32: datapath width, 32 or 64.
REQ-002 Param MUL_LAT, default 3: multiply cycles in MUL state, range 1..8.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ds_to_es_valid  in  1  decode presents an instruction.
REQ-006 es_allowin  out  1  stage accepts an instruction this cycle.
REQ-007 ms_allowin  in  1  memory stage accepts.
REQ-008 es_to_ms_valid  out  1  result valid toward memory stage.
REQ-009 flush  in  1  kill the held instruction, e.g. on a taken jump.
REQ-010 op1, op2  in  XLEN  source operands.
REQ-011 alu_op  in  5  encoded operation; codes defined in the package.
REQ-012 rd_in  in  5  destination register.
REQ-013 rd_wen_in  in  1  destination write enable.
REQ-014 pc_in  in  XLEN  instruction PC.
REQ-015 res_out  out  XLEN  result.
REQ-016 rd_out  out  5  latched rd.
REQ-017 rd_wen_out  out  1  latched rd_wen, gated by es_valid.
REQ-018 pc_out  out  XLEN  latched PC.
REQ-019 busy  out  1  FSM not IDLE.
REQ-020 fwd_valid  out  1  es_valid && es_ready_go && rd_wen && rd!=0, for the decode bypass.

Function
REQ-021 es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go.
REQ-022 Capture: inputs latch on ds_to_es_valid && es_allowin; es_valid then loads ds_to_es_valid whenever es_allowin is high.
REQ-023 ALU ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, COPY1): combinational; es_ready_go=1 in the capture cycle; shift amount uses op2[log2(XLEN)-1:0].
REQ-024 FSM states: IDLE, MUL, DIV, DONE; busy = (state != IDLE).
REQ-025 IDLE -> MUL when a valid MUL/MULH/MULHSU/MULHU is held; counter loads MUL_LAT-1; at 0 go to DONE.
REQ-026 IDLE -> DIV when a valid DIV/DIVU/REM/REMU is held; run XLEN restoring iterations, one per cycle, on magnitudes; at the end apply signs, then DONE.
REQ-027 Divide by zero: IDLE -> DONE directly; quotient = all ones, remainder = op1.
REQ-028 Signed overflow (op1 = most negative, op2 = -1): IDLE -> DONE; quotient = op1, remainder = 0.
REQ-029 MULH, MULHSU, MULHU return the upper XLEN bits of the 2*XLEN product; MUL returns the lower XLEN bits.
REQ-030 es_ready_go = 0 in IDLE, MUL and DIV for M ops; 1 in DONE.
REQ-031 DONE holds res_out until ms_allowin, then goes to IDLE on the same edge the next instruction may be captured.
REQ-032 Residency: normal division XLEN+2 cycles; multiply MUL_LAT+2 cycles; special-case division 2 cycles.
REQ-033 flush, at any state: es_valid <= 0 and FSM <= IDLE next edge; no es_to_ms_valid in the flush cycle; flush overrides a simultaneous capture.
REQ-034 Undefined alu_op: res_out = 0, es_ready_go = 1.

Reset
REQ-035 On rst_n low: es_valid=0, FSM=IDLE, counters=0, latched fields=0.
REQ-036 Therefore es_to_ms_valid=0, busy=0, fwd_valid=0, res_out=0, es_allowin=1; reset mid-division aborts it.

Configuration
REQ-037 With macro EXE_STAGE_MULDIV_EN defined: MUL and DIV states present.
REQ-038 Without the macro: M-op codes behave as undefined (REQ-034); FSM absent; busy tied 0.

Structure
REQ-039 Package exe_pkg holds the alu_op code constants, the FSM state enum and the ALU_OP_W=5 width constant.
REQ-040 Sub-module exe_muldiv_unit holds the FSM, counter and divider/multiplier datapath; the top holds the handshake, pipeline register and ALU.

Verification
REQ-041 ADD 5+7, ms_allowin=1 -> es_to_ms_valid the capture cycle, res_out=12.
REQ-042 DIV -20/3 (XLEN=32) -> es_ready_go low 33 cycles, then res_out=-6; REM yields -2.
REQ-043 DIVU 9/0 -> res_out=0xFFFFFFFF after 2 cycles; REMU 9/0 -> 9.
REQ-044 DIV 0x80000000/-1 -> quotient 0x80000000; REM -> 0.
REQ-045 MULHU 0xFFFFFFFF*0xFFFFFFFF, MUL_LAT=3 -> res_out=0xFFFFFFFE after 5 cycles.
REQ-046 flush on the 10th DIV cycle -> busy=0 and es_allowin=1 next cycle, no result emitted; ms_allowin held 0 in DONE -> res_out stable.
